// File: rtl/shim_cfg_shadow_bank.sv
// Per-channel configuration shadow bank: a new word is committed only after it has been stable.
// Optional SHIM_CFG_SHADOW_LOCK_EN lets an active lock defer commits (HOLD state).
module shim_cfg_shadow_bank #(
    parameter int NUM_CH        = 4,
    parameter int WIDTH         = 32,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] din,
    input  logic [NUM_CH*WIDTH-1:0] dout_default,
    input  logic                    lock,
    output logic [NUM_CH*WIDTH-1:0] dout,
    output logic [NUM_CH-1:0]       update,
    output logic [NUM_CH-1:0]       pending,
    output logic                    all_idle
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    logic lock_eff;
`ifdef SHIM_CFG_SHADOW_LOCK_EN
    assign lock_eff = lock;
`else
    // Port kept for interface compatibility; commits never wait on it.
    logic unused_lock;
    assign unused_lock = lock;
    assign lock_eff    = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t             state, state_nxt;
        logic [WIDTH-1:0]   cand, cand_nxt;
        logic [WIDTH-1:0]   dout_r, dout_nxt;
        logic [CNT_W-1:0]   cnt, cnt_nxt;
        logic               upd_r, upd_nxt;
        logic [WIDTH-1:0]   din_i;

        assign din_i = din[i*WIDTH +: WIDTH];

        always_comb begin
            state_nxt = state;
            cand_nxt  = cand;
            cnt_nxt   = cnt;
            dout_nxt  = dout_r;
            upd_nxt   = 1'b0;
            case (state)
                IDLE: begin
                    if (din_i != dout_r) begin
                        cand_nxt  = din_i;
                        cnt_nxt   = '0;
                        state_nxt = SETTLE;
                    end
                end
                SETTLE, HOLD: begin
                    if (din_i != cand) begin
                        // Any movement restarts settling; returning to dout aborts silently.
                        cand_nxt  = din_i;
                        cnt_nxt   = '0;
                        state_nxt = (din_i == dout_r) ? IDLE : SETTLE;
                    end else if (state == SETTLE && cnt != CNT_LAST) begin
                        cnt_nxt = cnt + 1'b1;
                    end else if (lock_eff) begin
                        state_nxt = HOLD;
                    end else begin
                        dout_nxt  = cand;
                        upd_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= IDLE;
                cand   <= '0;
                cnt    <= '0;
                dout_r <= dout_default[i*WIDTH +: WIDTH];
                upd_r  <= 1'b0;
            end else begin
                state  <= state_nxt;
                cand   <= cand_nxt;
                cnt    <= cnt_nxt;
                dout_r <= dout_nxt;
                upd_r  <= upd_nxt;
            end
        end

        assign dout[i*WIDTH +: WIDTH] = dout_r;
        assign update[i]              = upd_r;
        assign pending[i]             = (state != IDLE);
    end

    assign all_idle = ~|pending;

endmodule
